rv32i_halt_monitor: RTL and testbench

RV32I_HALT_MONITOR -- requirements
Module: rv32i_halt_monitor

---
 rtl/rv32i_mon_pkg.sv | 15 +
 rtl/rv32i_mon_counter.sv | 31 +++
 rtl/rv32i_halt_monitor.sv | 130 +++++++++++++
 tb/tb_rv32i_halt_monitor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_mon_pkg.sv
// Shared types and constants for the RV32I halt monitor.
// Holds the FSM state encoding and the canonical self-jump word.
package rv32i_mon_pkg;

  typedef logic [1:0] mon_state_t;

  localparam mon_state_t ST_IDLE    = 2'd0;
  localparam mon_state_t ST_RUN     = 2'd1;
  localparam mon_state_t ST_SUSPECT = 2'd2;
  localparam mon_state_t ST_HALTED  = 2'd3;

  // jal x0, 0 : the conventional "spin here forever" end of program
  localparam logic [31:0] RV32I_HALT_INSN = 32'h0000_006F;

endpackage

// File: rtl/rv32i_mon_counter.sv
// 32-bit wrapping event counter for the halt monitor.
// Ports: clk_i, reset_i (async, high), clear_i (sync), en_i, count_o.
module rv32i_mon_counter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (en_i)
      count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/rv32i_halt_monitor.sv
// Detects end of program: HALT_COUNT consecutive fetches of HALT_INSN
// at one PC. Sticky halt until clear_i or reset_i.
// Ports: clk_i, reset_i (async, high), fetch_valid_i, imem_addr_i,
//   imem_data_i, clear_i (sync) ; halt_o, halt_pc_o, running_o,
//   cycle_count_o, instret_o.
// Macro HALT_MON_PERF_EN builds the perf counters; otherwise they
// read constant 0.
module rv32i_halt_monitor
  import rv32i_mon_pkg::*;
#(
  parameter logic [31:0] HALT_INSN  = RV32I_HALT_INSN,
  parameter int unsigned HALT_COUNT = 5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] imem_addr_i,
  input  logic [31:0] imem_data_i,
  input  logic        clear_i,
  output logic        halt_o,
  output logic [31:0] halt_pc_o,
  output logic        running_o,
  output logic [31:0] cycle_count_o,
  output logic [31:0] instret_o
);

  localparam int SW = $clog2(HALT_COUNT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(HALT_COUNT);

  mon_state_t    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [31:0]   spc_q, spc_d;
  logic [31:0]   hpc_q, hpc_d;

  logic is_halt;
  logic same_pc;
  logic streak_full;

  assign is_halt     = (imem_data_i == HALT_INSN);
  assign same_pc     = (imem_addr_i == spc_q);
  assign streak_full = (streak_q == STREAK_MAX);

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    spc_d    = spc_q;
    hpc_d    = hpc_q;
    if (clear_i) begin
      state_d  = ST_IDLE;
      streak_d = '0;
      spc_d    = '0;
      hpc_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_RUN, ST_SUSPECT: begin
          // A full streak is registered one edge before halt is
          // declared; fetches in that cycle do not touch the streak.
          if (streak_full) begin
            state_d = ST_HALTED;
            hpc_d   = spc_q;
          end else if (fetch_valid_i) begin
            if (is_halt) begin
              state_d = ST_SUSPECT;
              if (streak_q != '0 && same_pc) begin
                streak_d = streak_q + SW'(1);
              end else begin
                // new streak, or restart at a different PC
                streak_d = SW'(1);
                spc_d    = imem_addr_i;
              end
            end else begin
              state_d  = ST_RUN;
              streak_d = '0;
            end
          end
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      streak_q <= '0;
      spc_q    <= '0;
      hpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      spc_q    <= spc_d;
      hpc_q    <= hpc_d;
    end
  end

  assign halt_o    = (state_q == ST_HALTED);
  assign halt_pc_o = hpc_q;
  assign running_o = (state_q == ST_RUN) || (state_q == ST_SUSPECT);

`ifdef HALT_MON_PERF_EN
  logic cyc_en;
  logic ins_en;

  assign cyc_en = running_o;
  // the fetch that leaves IDLE is retired too
  assign ins_en = fetch_valid_i &&
                  (running_o || (state_q == ST_IDLE));

  rv32i_mon_counter u_cyc (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .en_i    (cyc_en),
    .count_o (cycle_count_o)
  );

  rv32i_mon_counter u_ins (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .en_i    (ins_en),
    .count_o (instret_o)
  );
`else
  assign cycle_count_o = '0;
  assign instret_o     = '0;
`endif

endmodule

// File: tb/tb_rv32i_halt_monitor.sv
// Directed self-checking bench for rv32i_halt_monitor.
// A second instance with HALT_COUNT=1 covers the single-fetch case.
module tb_rv32i_halt_monitor;

  localparam logic [31:0] HI  = 32'h0000_006F;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        fv;
  logic [31:0] addr;
  logic [31:0] data;
  logic        clr;

  logic        halt;
  logic [31:0] hpc;
  logic        run;
  logic [31:0] cyc;
  logic [31:0] ins;

  logic        halt1;
  logic [31:0] hpc1;
  logic        run1;
  logic [31:0] cyc1;
  logic [31:0] ins1;

  int checks;
  int fails;

  rv32i_halt_monitor dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .fetch_valid_i (fv),
    .imem_addr_i   (addr),
    .imem_data_i   (data),
    .clear_i       (clr),
    .halt_o        (halt),
    .halt_pc_o     (hpc),
    .running_o     (run),
    .cycle_count_o (cyc),
    .instret_o     (ins)
  );

  rv32i_halt_monitor #(.HALT_COUNT(1)) dut1 (
    .clk_i         (clk),
    .reset_i       (rst),
    .fetch_valid_i (fv),
    .imem_addr_i   (addr),
    .imem_data_i   (data),
    .clear_i       (clr),
    .halt_o        (halt1),
    .halt_pc_o     (hpc1),
    .running_o     (run1),
    .cycle_count_o (cyc1),
    .instret_o     (ins1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a,
                       input logic [31:0] d);
    fv   = 1'b1;
    addr = a;
    data = d;
    @(posedge clk);
    #1;
    fv = 1'b0;
  endtask

  task automatic idle(input int n);
    fv = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  logic [31:0] exp_cyc;
  logic [31:0] exp_ins;

  initial begin
    checks = 0;
    fails  = 0;
    rst  = 1'b1;
    clr  = 1'b0;
    fv   = 1'b0;
    addr = '0;
    data = '0;
    #12;
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_run", {31'd0, run}, 32'd0);
    chk("rst_pc", hpc, 32'd0);
    chk("rst_cyc", cyc, 32'd0);
    chk("rst_ins", ins, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // first fetch: HALT_COUNT=1 instance halts one edge later
    fetch(32'h100, HI);
    chk("t1_run", {31'd0, run}, 32'd1);
    idle(1);
    chk("hc1_halt", {31'd0, halt1}, 32'd1);
    chk("hc1_pc", hpc1, 32'h100);
    chk("t1_h1", {31'd0, halt}, 32'd0);
    repeat (3) fetch(32'h100, HI);
    idle(1);
    chk("t1_h4", {31'd0, halt}, 32'd0);
    fetch(32'h100, HI);
    chk("t1_lat", {31'd0, halt}, 32'd0);
    idle(1);
    chk("t1_halt", {31'd0, halt}, 32'd1);
    chk("t1_pc", hpc, 32'h100);
    chk("t1_norun", {31'd0, run}, 32'd0);
    fetch(32'h40, NOP);
    chk("t1_sticky", {31'd0, halt}, 32'd1);

    // clear wins over a simultaneous fetch
    fv   = 1'b1;
    addr = 32'h200;
    data = HI;
    pulse_clear();
    fv = 1'b0;
    chk("clr_halt", {31'd0, halt}, 32'd0);
    chk("clr_run", {31'd0, run}, 32'd0);
    chk("clr_pc", hpc, 32'd0);
    chk("clr_cyc", cyc, 32'd0);
    chk("clr_ins", ins, 32'd0);

    // streak moves to a new PC
    repeat (3) fetch(32'h100, HI);
    repeat (4) fetch(32'h104, HI);
    idle(1);
    chk("t2_h4", {31'd0, halt}, 32'd0);
    fetch(32'h104, HI);
    idle(1);
    chk("t2_halt", {31'd0, halt}, 32'd1);
    chk("t2_pc", hpc, 32'h104);
    pulse_clear();

    // stalls do not break a streak
    for (int i = 0; i < 5; i++) begin
      fetch(32'h100, HI);
      idle(3);
    end
    chk("t3_halt", {31'd0, halt}, 32'd1);
    chk("t3_pc", hpc, 32'h100);
    pulse_clear();

    // a different instruction does
    repeat (2) fetch(32'h100, HI);
    fetch(32'h104, NOP);
    repeat (3) fetch(32'h100, HI);
    idle(2);
    chk("t3b_nohalt", {31'd0, halt}, 32'd0);
    chk("t3b_run", {31'd0, run}, 32'd1);
    repeat (2) fetch(32'h100, HI);
    idle(1);
    chk("t3b_halt", {31'd0, halt}, 32'd1);
    pulse_clear();

    // async reset mid-streak
    repeat (3) fetch(32'h100, HI);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_halt", {31'd0, halt}, 32'd0);
    chk("ar_run", {31'd0, run}, 32'd0);
    chk("ar_pc", hpc, 32'd0);
    chk("ar_cyc", cyc, 32'd0);
    chk("ar_ins", ins, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) fetch(32'h100, HI);
    idle(1);
    chk("ar_streak0", {31'd0, halt}, 32'd0);
    pulse_clear();

    // perf counters: 10 NOPs with 2 bubbles, then 5 halt fetches
    for (int i = 0; i < 10; i++) begin
      fetch(32'(i * 4), NOP);
      if (i == 3 || i == 6) idle(1);
    end
    repeat (5) fetch(32'h100, HI);
    idle(1);
    chk("t5_halt", {31'd0, halt}, 32'd1);
`ifdef HALT_MON_PERF_EN
    exp_cyc = 32'd17;
    exp_ins = 32'd15;
`else
    exp_cyc = 32'd0;
    exp_ins = 32'd0;
`endif
    chk("t5_ins", ins, exp_ins);
    chk("t5_cyc", cyc, exp_cyc);
    fetch(32'h100, HI);
    idle(4);
    chk("t5_ins_frz", ins, exp_ins);
    chk("t5_cyc_frz", cyc, exp_cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
